// File: rtl/keypad_scan_fifo.sv
// keypad_scan_fifo
//   Matrix keypad scanner for ROWS x COLS keypads. Columns are driven
//   one at a time (active-low) for SCAN_DIV clocks each. The row sense
//   is sampled at the end of each column dwell, and the samples are
//   folded into a per-frame result: NONE, SINGLE(code) or MULTI.
//   Each new accepted single key is queued as one press event in a
//   show-ahead FIFO. The accepted state needs DEBOUNCE_FRAMES identical
//   non-MULTI frames in a row.
//
// Ports
//   clk        system clock
//   res        synchronous active-high reset
//   row_in     row sense, active-low, already synchronised
//   col_drive  one-hot active-low column drive
//   key_code   FIFO head code (col*ROWS + row); held when empty
//   key_valid  FIFO non-empty
//   key_ready  consumer pop request (pop = key_valid & key_ready)
//   key_down   debounced "exactly one key held"
//   held_code  code of the held key, meaningful while key_down=1
//   multi_key  last completed frame saw more than one key
//   overflow   sticky: a press event was dropped on a full FIFO
//   ovf_clr    clears overflow (a simultaneous drop wins)
module keypad_scan_fifo #(
   parameter int ROWS            = 4,
   parameter int COLS            = 4,
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_FRAMES = 3,
   parameter int FIFO_DEPTH      = 8,
   parameter int CW              = $clog2(ROWS*COLS)
) (
   input  logic            clk,
   input  logic            res,
   input  logic [ROWS-1:0] row_in,
   output logic [COLS-1:0] col_drive,
   output logic [CW-1:0]   key_code,
   output logic            key_valid,
   input  logic            key_ready,
   output logic            key_down,
   output logic [CW-1:0]   held_code,
   output logic            multi_key,
   output logic            overflow,
   input  logic            ovf_clr
);

   localparam int DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CIW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int NW  = $clog2(FIFO_DEPTH + 1);
   localparam int DBW = $clog2(DEBOUNCE_FRAMES + 1);

   typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} frame_res_t;

   logic [DW-1:0]  div_cnt;
   logic [CIW-1:0] col_idx;
   logic           tick;
   logic           frame_end;

   assign tick      = (div_cnt == DW'(SCAN_DIV - 1));
   assign frame_end = tick && (col_idx == CIW'(COLS - 1));

   // Low-bit count of the current column (saturating at 2) and the row of a low bit
   logic [1:0]    col_low;
   logic [RW-1:0] col_row;
   logic [CW-1:0] col_code;

   always_comb begin
      col_low = '0;
      col_row = '0;
      for (int unsigned r = 0; r < ROWS; r++) begin
         if (!row_in[r]) begin
            if (col_low != 2'd2) col_low = col_low + 2'd1;
            col_row = RW'(r);
         end
      end
   end

   assign col_code = CW'(col_idx) * CW'(ROWS) + CW'(col_row);

   // Frame accumulator: saturating low-bit total plus the code of the single hit
   logic [1:0]    acc_low;
   logic [CW-1:0] acc_code;
   logic [2:0]    sum_raw;
   logic [1:0]    sum_low;
   logic [CW-1:0] sum_code;
   frame_res_t    frame_res;

   assign sum_raw  = {1'b0, acc_low} + {1'b0, col_low};
   assign sum_low  = (sum_raw > 3'd2) ? 2'd2 : sum_raw[1:0];
   assign sum_code = (col_low == 2'd1) ? col_code : acc_code;

   always_comb begin
      case (sum_low)
         2'd0:    frame_res = RES_NONE;
         2'd1:    frame_res = RES_SINGLE;
         default: frame_res = RES_MULTI;
      endcase
   end

   // Debounce: candidate plus saturating repeat count; MULTI frames are ignored
   logic           cand_single;
   logic [CW-1:0]  cand_code;
   logic [DBW-1:0] db_cnt;
   logic           match;
   logic           cand_single_n;
   logic [CW-1:0]  cand_code_n;
   logic [DBW-1:0] db_cnt_n;
   logic           accept;
   logic           push_new;
   logic           push_req;
   logic [CW-1:0]  push_code;

   always_comb begin
      match = ((frame_res == RES_NONE) && !cand_single) ||
              ((frame_res == RES_SINGLE) && cand_single && (sum_code == cand_code));
      cand_single_n = cand_single;
      cand_code_n   = cand_code;
      db_cnt_n      = db_cnt;
      if (frame_res != RES_MULTI) begin
         if (match) begin
            if (db_cnt != DBW'(DEBOUNCE_FRAMES)) db_cnt_n = db_cnt + DBW'(1);
         end else begin
            cand_single_n = (frame_res == RES_SINGLE);
            cand_code_n   = sum_code;
            db_cnt_n      = DBW'(1);
         end
      end
      accept   = frame_end && (frame_res != RES_MULTI) && (db_cnt_n == DBW'(DEBOUNCE_FRAMES));
      push_new = accept && cand_single_n && !(key_down && (held_code == cand_code_n));
   end

   always_ff @(posedge clk) begin
      if (res) begin
         div_cnt     <= '0;
         col_idx     <= '0;
         col_drive   <= ~COLS'(1);
         acc_low     <= '0;
         acc_code    <= '0;
         cand_single <= 1'b0;
         cand_code   <= '0;
         db_cnt      <= '0;
         key_down    <= 1'b0;
         held_code   <= '0;
         multi_key   <= 1'b0;
         push_req    <= 1'b0;
         push_code   <= '0;
      end else begin
         push_req <= push_new;
         if (push_new) push_code <= cand_code_n;
         if (tick) begin
            div_cnt <= '0;
            if (frame_end) begin
               col_idx     <= '0;
               col_drive   <= ~COLS'(1);
               acc_low     <= '0;
               acc_code    <= '0;
               multi_key   <= (frame_res == RES_MULTI);
               cand_single <= cand_single_n;
               cand_code   <= cand_code_n;
               db_cnt      <= db_cnt_n;
               if (accept) begin
                  key_down <= cand_single_n;
                  if (cand_single_n) held_code <= cand_code_n;
               end
            end else begin
               col_idx   <= col_idx + CIW'(1);
               col_drive <= ~(COLS'(1) << (col_idx + CIW'(1)));
               acc_low   <= sum_low;
               acc_code  <= sum_code;
            end
         end else begin
            div_cnt <= div_cnt + DW'(1);
         end
      end
   end

   // Event FIFO with a registered show-ahead head
   logic [CW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_n;
   logic [NW-1:0] fcnt;
   logic [NW-1:0] fcnt_n;
   logic          full;
   logic          pop;
   logic          push_ok;
   logic          drop;

   assign key_valid = (fcnt != '0);

   always_comb begin
      full    = (fcnt == NW'(FIFO_DEPTH));
      pop     = key_valid && key_ready;
      push_ok = push_req && (!full || pop);
      drop    = push_req && full && !pop;
      rd_n    = rd_ptr + AW'(pop);
      fcnt_n  = fcnt + NW'(push_ok) - NW'(pop);
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_code;
   end

   always_ff @(posedge clk) begin
      if (res) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fcnt     <= '0;
         key_code <= '0;
         overflow <= 1'b0;
      end else begin
         rd_ptr <= rd_n;
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         fcnt <= fcnt_n;
         // The next head is the incoming entry only when nothing older remains
         if (fcnt_n != '0)
            key_code <= (push_ok && (rd_n == wr_ptr)) ? push_code : mem[rd_n];
         if (drop)
            overflow <= 1'b1;
         else if (ovf_clr)
            overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// tb_keypad_scan_fifo
//   Directed stimulus for keypad_scan_fifo (4x4, SCAN_DIV=4, 2-frame
//   debounce, 4-entry FIFO). A keypad model turns the pressed-key mask
//   into row_in from col_drive. A frame-level reference model predicts
//   every output, and the outputs are compared to it each cycle. Literal
//   checks at key points pin the model itself.
module tb_keypad_scan_fifo;

   localparam int ROWS     = 4;
   localparam int COLS     = 4;
   localparam int SCAN_DIV = 4;
   localparam int DEB      = 2;
   localparam int DEPTH    = 4;
   localparam int CW       = 4;
   localparam int FRAME    = COLS * SCAN_DIV;

   logic            clk = 1'b0;
   logic            res = 1'b1;
   logic [ROWS-1:0] row_in;
   logic [COLS-1:0] col_drive;
   logic [CW-1:0]   key_code;
   logic            key_valid;
   logic            key_ready = 1'b0;
   logic            key_down;
   logic [CW-1:0]   held_code;
   logic            multi_key;
   logic            overflow;
   logic            ovf_clr = 1'b0;

   logic [ROWS*COLS-1:0] pressed = '0;

   int vectors     = 0;
   int miscompares = 0;

   keypad_scan_fifo #(
      .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
      .DEBOUNCE_FRAMES(DEB), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .res(res), .row_in(row_in), .col_drive(col_drive),
      .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
      .key_down(key_down), .held_code(held_code), .multi_key(multi_key),
      .overflow(overflow), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   // Keypad: a pressed key pulls its row low while its column is driven low
   always_comb begin
      row_in = '1;
      for (int c = 0; c < COLS; c++)
         for (int r = 0; r < ROWS; r++)
            if (!col_drive[c] && pressed[c*ROWS+r]) row_in[r] = 1'b0;
   end

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
      end
   endtask

   // Reference model state, describing the current cycle
   int  t;
   bit  started = 1'b0;
   int  frame_keys[$];
   int  hist[$];
   bit  m_down;
   int  m_held;
   bit  m_multi;
   int  m_fifo[$];
   bit  m_ovf;
   int  m_code;
   bit  pend;
   int  pend_code;

   always @(negedge clk) begin : model
      bit popped, full, drop, stable;
      int col, acc;
      if (started) begin
         chk("col_drive", col_drive, 15 & ~(1 << ((t / SCAN_DIV) % COLS)));
         chk("key_valid", key_valid, int'(m_fifo.size() > 0));
         chk("key_code", key_code, m_code);
         chk("key_down", key_down, m_down);
         if (m_down) chk("held_code", held_code, m_held);
         chk("multi_key", multi_key, m_multi);
         chk("overflow", overflow, m_ovf);
      end
      if (res) begin
         started = 1'b1;
         t = 0;
         frame_keys.delete();
         hist.delete();
         m_fifo.delete();
         m_down = 0; m_held = 0; m_multi = 0; m_ovf = 0; m_code = 0; pend = 0;
      end else begin
         popped = (m_fifo.size() > 0) && key_ready;
         full   = (m_fifo.size() == DEPTH);
         drop   = pend && full && !popped;
         if (popped) void'(m_fifo.pop_front());
         if (pend && !drop) m_fifo.push_back(pend_code);
         if (drop) m_ovf = 1;
         else if (ovf_clr) m_ovf = 0;
         if (m_fifo.size() > 0) m_code = m_fifo[0];
         pend = 0;
         if (t % SCAN_DIV == SCAN_DIV - 1) begin
            col = (t / SCAN_DIV) % COLS;
            for (int r = 0; r < ROWS; r++)
               if (pressed[col*ROWS+r]) frame_keys.push_back(col*ROWS + r);
            if (col == COLS - 1) begin
               if (frame_keys.size() > 1) begin
                  m_multi = 1;
               end else begin
                  m_multi = 0;
                  hist.push_back(frame_keys.size() == 0 ? -1 : frame_keys[0]);
                  stable = 0;
                  if (hist.size() >= DEB) begin
                     stable = 1;
                     for (int i = 1; i < DEB; i++)
                        if (hist[hist.size()-1-i] != hist[hist.size()-1]) stable = 0;
                  end
                  if (stable) begin
                     acc = hist[hist.size()-1];
                     if (acc >= 0 && !(m_down && m_held == acc)) begin
                        pend = 1;
                        pend_code = acc;
                     end
                     m_down = (acc >= 0);
                     if (acc >= 0) m_held = acc;
                  end
               end
               frame_keys.delete();
            end
         end
         t++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic frames(input int n);
      cyc(n * FRAME);
   endtask

   task automatic align();
      while (t % FRAME != 0) cyc(1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   logic [3:0] colseq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   int         ev [5]     = '{1, 2, 3, 4, 9};

   initial begin
      res = 1'b1;
      cyc(3);
      res = 1'b0;
      chk("rst_col_drive", col_drive, 4'b1110);
      chk("rst_key_valid", key_valid, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_key_down", key_down, 0);
      for (int i = 0; i < FRAME; i++) begin
         chk("col_seq", col_drive, colseq[i / SCAN_DIV]);
         cyc(1);
      end

      // Key 6: accepted after two frames, queued one cycle later, single event
      pressed = 16'h0040;
      frames(2);
      chk("k6_down", key_down, 1);
      chk("k6_held", held_code, 6);
      chk("k6_valid_early", key_valid, 0);
      cyc(1);
      chk("k6_valid", key_valid, 1);
      chk("k6_code", key_code, 6);
      cyc(FRAME - 1);

      // Release then key 15; pop both events
      pressed = '0;
      frames(2);
      chk("rel_down", key_down, 0);
      pressed = 16'h8000;
      frames(2);
      chk("k15_held", held_code, 15);
      cyc(2);
      key_ready = 1'b1;
      chk("pop1_code", key_code, 6);
      cyc(1);
      chk("pop2_code", key_code, 15);
      chk("pop2_valid", key_valid, 1);
      cyc(1);
      chk("pop_empty", key_valid, 0);
      chk("pop_hold_code", key_code, 15);
      key_ready = 1'b0;
      align();
      pressed = '0;
      frames(2);

      // One-frame glitch on key 3
      pressed = 16'h0008;
      frames(1);
      pressed = '0;
      frames(2);
      chk("glitch_down", key_down, 0);
      chk("glitch_valid", key_valid, 0);

      // Key 5 held, then keys 0 and 5 together
      pressed = 16'h0020;
      frames(2);
      chk("k5_down", key_down, 1);
      pressed = 16'h0021;
      frames(2);
      chk("multi_flag", multi_key, 1);
      chk("multi_down", key_down, 1);
      chk("multi_held", held_code, 5);
      cyc(1);
      chk("multi_one_event", key_code, 5);
      align();
      pressed = '0;
      frames(1);
      chk("multi_clear", multi_key, 0);
      frames(1);
      chk("multi_rel", key_down, 0);
      key_ready = 1'b1;
      cyc(1);
      key_ready = 1'b0;
      chk("multi_popped", key_valid, 0);

      // Five presses with no consumer: four queued, one dropped
      align();
      for (int i = 0; i < 5; i++) begin
         pressed = 16'(1 << ev[i]);
         frames(2);
         pressed = '0;
         frames(2);
      end
      chk("ovf_set", overflow, 1);
      key_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("ovf_valid", key_valid, 1);
         chk("ovf_code", key_code, ev[i]);
         cyc(1);
      end
      key_ready = 1'b0;
      chk("ovf_empty", key_valid, 0);
      chk("ovf_sticky", overflow, 1);
      ovf_clr = 1'b1;
      cyc(1);
      ovf_clr = 1'b0;
      chk("ovf_cleared", overflow, 0);

      // Reset mid-frame with entries queued
      align();
      pressed = 16'h0080;
      frames(2);
      pressed = 16'h0100;
      frames(2);
      pressed = '0;
      cyc(5);
      chk("pre_res_valid", key_valid, 1);
      chk("pre_res_code", key_code, 7);
      res = 1'b1;
      cyc(1);
      res = 1'b0;
      chk("res_valid", key_valid, 0);
      chk("res_col", col_drive, 4'b1110);
      chk("res_down", key_down, 0);
      frames(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
